fp_tree_accumulator: RTL and testbench
======================================

# fp_tree_accumulator

Downstream consumer of `fp_add_tree`: collects successive bfloat16 partial sums from the tree's `result`/`result_valid` port and accumulates a programmable number of them onto a bias. It applies optional ReLU and presents one output word per accumulation window over a valid/ready handshake. It closes the dot-product path for convolution or fully-connected output neurons whose fan-in exceeds one tree pass. It uses a small input FIFO and a multi-cycle sequential FP adder.

## Interface
- `EXP`, 8, exponent width
- `MANT`, 7, stored mantissa width
- `WIDTH`, 16, word width; must equal 1+`EXP`+`MANT`
- `FIFO_DEPTH`, 4, input FIFO entries (power of two, ≥2)
- `COUNT_W`, 8, width of beat counter
- `clock` in 1: single clock, all state on rising edge
- `clock_areset_n` in 1: asynchronous assert, active-low reset
- `data_valid` in 1: tree result strobe
- `data` in `WIDTH`: tree result
- `in_ready` out 1: combinational `!fifo_full`
- `beats` in `COUNT_W`: tree results per window; 0 is treated as 1
- `bias` in `WIDTH`: accumulator start value
- `relu_en` in 1: clamp negative results to +0
- `result_valid` out 1: output word valid
- `result` out `WIDTH`: accumulated word
- `result_ready` in 1: downstream accept
- `overflow` out 1: sticky; set on exponent saturation
- `drop_err` out 1: sticky; set when `data_valid && !in_ready`

## Operation
- FIFO push when `data_valid && in_ready`. A word offered while full is dropped and sets `drop_err`. Push and pop in the same cycle are both performed.
- FSM states: IDLE, WAIT, POP, ALIGN, ADD, NORM, OUT.
- IDLE: when FIFO is non-empty, latch `acc<=bias`, `cnt<=max(beats,1)` and `relu_en`, then go to POP. `beats`, `bias` and `relu_en` are ignored at all other times.
- POP: `b<=fifo head`, pop one entry, go to ALIGN.
- ALIGN: expand both operands with the hidden bit.
  - An operand with exponent 0 is +0 (subnormals flushed).
  - Right-shift the smaller-exponent mantissa by the exponent difference. Bits shifted out are discarded.
  - A difference > `MANT`+1 yields zero.
  - Go to ADD.
- ADD: sign-magnitude add on same signs. On different signs, subtract smaller magnitude from larger; the result takes the sign of the larger. Go to NORM.
- NORM: leading-one detect and shift to normalise, with truncation (round toward zero).
  - Zero magnitude → 0x0000 (+0).
  - Exponent underflow → +0.
  - Exponent ≥ all-ones → sign | max finite (0x7F7F / 0xFF7F) and set `overflow`.
  - Write `acc` and decrement `cnt`. Next state: `cnt==0` → OUT; else FIFO non-empty → POP; else → WAIT.
- WAIT: FIFO non-empty → POP.
- OUT: `result_valid=1`; `result = (relu_en_latched && acc[WIDTH-1]) ? 0 : acc`. On `result_ready` go to IDLE. `result` is stable while `result_valid && !result_ready`.
- Inputs with exponent all-ones are processed as ordinary numbers; no NaN/Inf semantics.

## Timing
- Reset, asynchronous, while `clock_areset_n`=0:
  - `result_valid`=0, `result`=0, `overflow`=0, `drop_err`=0.
  - FIFO empty, so `in_ready`=1. Pushes are ignored while reset is asserted.
  - FSM returns to IDLE, `acc`/`cnt` are cleared, and an in-flight window is lost.
- Latency:
  - Word sampled at edge E0 with FSM in IDLE and FIFO empty: POP at E1, ALIGN E2, ADD E3, NORM E4.
  - With `beats`=1, `result_valid` rises after E5, i.e. 5 cycles.
  - Each further beat adds 4 cycles if already queued.
- Throughput is one tree word per 4 cycles. Back-to-back tree bursts up to `FIFO_DEPTH` are absorbed without loss.
- Minimum OUT→IDLE→POP turnaround is 2 cycles. Words arriving during OUT are queued for the next window.
- `overflow` and `drop_err` clear only on reset.

## Test plan
- `bias`=0x3F80, `beats`=2; push 0x4000 then 0x4040 on consecutive cycles → single `result`=0x40C0 (6.0), `result_valid` 9 cycles after first push, `drop_err`=0.
- `bias`=0xC0A0, `beats`=1, `relu_en`=1; push 0x3F80 → `result`=0x0000. Repeat with `relu_en`=0 → 0xC080.
- `bias`=0x4000, `beats`=1; push 0xC000 → `result`=0x0000 (cancellation to +0).
- `bias`=0x7F7F, `beats`=1; push 0x7F7F → `result`=0x7F7F, `overflow`=1 held until reset.
- Push 6 words on 6 consecutive cycles with FIFO_DEPTH=4 → at least one dropped, `in_ready` low while full, `drop_err`=1.
- Hold `result_ready`=0 for 10 cycles in OUT → `result_valid`/`result` stable. Then assert `clock_areset_n`=0 mid-window → all outputs 0 immediately, FIFO empty.

Source files
------------

// File: rtl/fp_tree_accumulator_if.sv
// Stream bundle between the adder tree, the accumulator and its consumer.
// Slave side is the accumulator; master side feeds words and accepts results.
interface fp_tree_accumulator_if #(
   parameter int WIDTH = 16
);
   logic             data_valid;
   logic [WIDTH-1:0] data;
   logic             in_ready;
   logic             result_valid;
   logic [WIDTH-1:0] result;
   logic             result_ready;

   modport master (
      output data_valid, data, result_ready,
      input  in_ready, result_valid, result
   );

   modport slave (
      input  data_valid, data, result_ready,
      output in_ready, result_valid, result
   );
endinterface

// File: rtl/fp_tree_accumulator.sv
// Accumulates a window of bfloat16 tree partial sums onto a bias through a
// small FIFO and a multi-cycle truncating FP adder, with optional ReLU.
module fp_tree_accumulator #(
   parameter int EXP        = 8,
   parameter int MANT       = 7,
   parameter int WIDTH      = 16,
   parameter int FIFO_DEPTH = 4,
   parameter int COUNT_W    = 8
) (
   input  logic               clock,
   input  logic               clock_areset_n,
   fp_tree_accumulator_if.slave bus,
   input  logic [COUNT_W-1:0] beats,
   input  logic [WIDTH-1:0]   bias,
   input  logic               relu_en,
   output logic               overflow,
   output logic               drop_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int M2 = MANT + 2;
   localparam int EW = EXP + 2;
   localparam logic [EXP-1:0] DMAX = EXP'(MANT + 1);
   localparam logic [EW-1:0]  EMAX = {2'b00, {EXP{1'b1}}};

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT, S_POP, S_ALIGN, S_ADD, S_NORM, S_OUT
   } state_t;

   state_t state_q;

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]      wr_q, rd_q;
   logic             full, empty, push, pop;
   logic [WIDTH-1:0] head;

   logic [WIDTH-1:0]   acc_q, b_q, res_q;
   logic [COUNT_W-1:0] cnt_q;
   logic               relu_q, res_valid_q, ovf_q, drop_q;
   logic [MANT:0]      xm_q, ym_q;
   logic               xs_q, ys_q, sgn_q;
   logic [EXP-1:0]     ex_q;
   logic [M2-1:0]      sum_q;

   assign empty = (wr_q == rd_q);
   assign full  = (wr_q[AW] != rd_q[AW]) &&
                  (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign push  = bus.data_valid && !full;
   assign pop   = (state_q == S_POP);
   assign head  = mem_q[rd_q[AW-1:0]];

   assign bus.in_ready     = !full;
   assign bus.result_valid = res_valid_q;
   assign bus.result       = res_q;
   assign overflow         = ovf_q;
   assign drop_err         = drop_q;

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q[AW-1:0]] <= bus.data;
   end

   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
      end
   end

   // Alignment: larger-exponent operand becomes x, the other is truncated.
   logic [EXP-1:0] ea, eb, ed, ex_d;
   logic [MANT:0]  ma, mb, xm_d, ym_d;
   logic           sa, sb, xs_d, ys_d;

   always_comb begin
      ea = acc_q[WIDTH-2 -: EXP];
      eb = b_q[WIDTH-2 -: EXP];
      ma = (ea == '0) ? '0 : {1'b1, acc_q[MANT-1:0]};
      mb = (eb == '0) ? '0 : {1'b1, b_q[MANT-1:0]};
      sa = (ea != '0) && acc_q[WIDTH-1];
      sb = (eb != '0) && b_q[WIDTH-1];
      if (ea >= eb) begin
         ed   = ea - eb;
         ex_d = ea;
         xm_d = ma;
         xs_d = sa;
         ym_d = (ed > DMAX) ? '0 : (mb >> ed);
         ys_d = sb;
      end else begin
         ed   = eb - ea;
         ex_d = eb;
         xm_d = mb;
         xs_d = sb;
         ym_d = (ed > DMAX) ? '0 : (ma >> ed);
         ys_d = sa;
      end
   end

   logic [M2-1:0] sum_d;
   logic          sgn_d;

   always_comb begin
      if (xs_q == ys_q) begin
         sum_d = {1'b0, xm_q} + {1'b0, ym_q};
         sgn_d = xs_q;
      end else if (xm_q >= ym_q) begin
         sum_d = {1'b0, xm_q - ym_q};
         sgn_d = xs_q;
      end else begin
         sum_d = {1'b0, ym_q - xm_q};
         sgn_d = ys_q;
      end
   end

   logic [EW-1:0]    lz_d, en_d;
   logic [M2-1:0]    sh_d;
   logic [MANT-1:0]  nm_d;
   logic             ovf_d;
   logic [WIDTH-1:0] norm_d;

   always_comb begin
      lz_d = '0;
      for (int i = 0; i <= MANT; i++) begin
         if (sum_q[i]) lz_d = EW'(MANT - i);
      end
      sh_d   = sum_q << lz_d;
      ovf_d  = 1'b0;
      norm_d = '0;
      if (sum_q[M2-1]) begin
         en_d = {2'b00, ex_q} + EW'(1);
         nm_d = sum_q[MANT:1];
      end else begin
         en_d = {2'b00, ex_q} - lz_d;
         nm_d = sh_d[MANT-1:0];
      end
      // Zero or exponent reaching 0 both collapse to +0.
      if (sum_q == '0 ||
          (!sum_q[M2-1] && {2'b00, ex_q} <= lz_d)) begin
         norm_d = '0;
      end else if (en_d >= EMAX) begin
         ovf_d  = 1'b1;
         norm_d = {sgn_q, {(EXP-1){1'b1}}, 1'b0, {MANT{1'b1}}};
      end else begin
         norm_d = {sgn_q, en_d[EXP-1:0], nm_d};
      end
   end

   always_ff @(posedge clock or negedge clock_areset_n) begin
      if (!clock_areset_n) begin
         state_q     <= S_IDLE;
         acc_q       <= '0;
         b_q         <= '0;
         cnt_q       <= '0;
         relu_q      <= 1'b0;
         xm_q        <= '0;
         ym_q        <= '0;
         xs_q        <= 1'b0;
         ys_q        <= 1'b0;
         ex_q        <= '0;
         sum_q       <= '0;
         sgn_q       <= 1'b0;
         res_q       <= '0;
         res_valid_q <= 1'b0;
         ovf_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         if (bus.data_valid && full) drop_q <= 1'b1;
         unique case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  acc_q   <= bias;
                  cnt_q   <= (beats == '0) ? COUNT_W'(1) : beats;
                  relu_q  <= relu_en;
                  state_q <= S_POP;
               end
            end
            S_WAIT: begin
               if (!empty) state_q <= S_POP;
            end
            S_POP: begin
               b_q     <= head;
               state_q <= S_ALIGN;
            end
            S_ALIGN: begin
               xm_q    <= xm_d;
               ym_q    <= ym_d;
               xs_q    <= xs_d;
               ys_q    <= ys_d;
               ex_q    <= ex_d;
               state_q <= S_ADD;
            end
            S_ADD: begin
               sum_q   <= sum_d;
               sgn_q   <= sgn_d;
               state_q <= S_NORM;
            end
            S_NORM: begin
               acc_q <= norm_d;
               cnt_q <= cnt_q - COUNT_W'(1);
               if (ovf_d) ovf_q <= 1'b1;
               if (cnt_q == COUNT_W'(1)) begin
                  res_valid_q <= 1'b1;
                  res_q <= (relu_q && norm_d[WIDTH-1]) ? '0 : norm_d;
                  state_q <= S_OUT;
               end else if (!empty) begin
                  state_q <= S_POP;
               end else begin
                  state_q <= S_WAIT;
               end
            end
            S_OUT: begin
               if (bus.result_ready) begin
                  res_valid_q <= 1'b0;
                  res_q       <= '0;
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_tree_accumulator.sv
// Bench for fp_tree_accumulator: directed windows plus randomized windows
// checked against an integer-arithmetic bfloat16 accumulation model.
module tb_fp_tree_accumulator;

   logic        clock;
   logic        clock_areset_n;
   logic [7:0]  beats;
   logic [15:0] bias;
   logic        relu_en;
   logic        overflow;
   logic        drop_err;

   int vectors;
   int miscompares;
   bit m_ovf;

   fp_tree_accumulator_if #(.WIDTH(16)) ifc ();

   fp_tree_accumulator dut (
      .clock          (clock),
      .clock_areset_n (clock_areset_n),
      .bus            (ifc),
      .beats          (beats),
      .bias           (bias),
      .relu_en        (relu_en),
      .overflow       (overflow),
      .drop_err       (drop_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Truncating bfloat16 add from plain signed-integer significands.
   function automatic logic [15:0] m_add(logic [15:0] a, logic [15:0] b);
      int ea, eb, e, ma, mb, d, s, m;
      bit sg;
      ea = int'(a[14:7]);
      eb = int'(b[14:7]);
      ma = (ea == 0) ? 0 : 128 + int'(a[6:0]);
      mb = (eb == 0) ? 0 : 128 + int'(b[6:0]);
      if (ea < eb) begin
         d = eb - ea; e = eb;
         ma = (d > 8) ? 0 : (ma >> d);
      end else begin
         d = ea - eb; e = ea;
         mb = (d > 8) ? 0 : (mb >> d);
      end
      s = (a[15] ? -ma : ma) + (b[15] ? -mb : mb);
      if (s == 0) return 16'h0000;
      sg = (s < 0);
      m = sg ? -s : s;
      while (m >= 256) begin m = m / 2; e++; end
      while (m < 128) begin m = m * 2; e--; end
      if (e <= 0) return 16'h0000;
      if (e >= 255) begin
         m_ovf = 1'b1;
         return sg ? 16'hFF7F : 16'h7F7F;
      end
      return {sg, 8'(e), 7'(m - 128)};
   endfunction

   function automatic logic [15:0] rnd_bf();
      logic [15:0] w;
      w[15]   = 1'($urandom_range(0, 1));
      w[14:7] = ($urandom_range(0, 9) == 0) ? 8'h00
                : 8'($urandom_range(110, 140));
      w[6:0]  = 7'($urandom);
      return w;
   endfunction

   task automatic push_word(input logic [15:0] w);
      int g;
      g = 0;
      while (!ifc.in_ready && g < 100) begin
         @(negedge clock);
         g++;
      end
      ifc.data_valid = 1'b1;
      ifc.data       = w;
      @(negedge clock);
      ifc.data_valid = 1'b0;
   endtask

   task automatic wait_valid(output int t);
      t = 0;
      while (!ifc.result_valid && t < 300) begin
         @(negedge clock);
         t++;
      end
      if (!ifc.result_valid) t = -1;
   endtask

   task automatic accept();
      ifc.result_ready = 1'b1;
      @(negedge clock);
      ifc.result_ready = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      clock_areset_n   = 1'b0;
      ifc.data_valid   = 1'b0;
      ifc.result_ready = 1'b0;
      m_ovf            = 1'b0;
      repeat (2) @(negedge clock);
      clock_areset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_reset();
      ifc.data_valid = 1'b1;
      ifc.data       = 16'h3F80;
      repeat (3) @(negedge clock);
      vectors++;
      if (ifc.result_valid !== 1'b0 || ifc.result !== 16'h0000 ||
          overflow !== 1'b0 || drop_err !== 1'b0 ||
          ifc.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_state: rv=%b res=%h ovf=%b drop=%b rdy=%b req 0/0000/0/0/1",
                  ifc.result_valid, ifc.result, overflow, drop_err, ifc.in_ready);
      end
      ifc.data_valid = 1'b0;
      @(negedge clock);
      clock_areset_n = 1'b1;
      repeat (12) @(negedge clock);
      vectors++;
      if (ifc.result_valid !== 1'b0 || ifc.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_push_ignored: rv=%b rdy=%b req 0/1",
                  ifc.result_valid, ifc.in_ready);
      end
   endtask

   task automatic test_two_beat();
      int t;
      bias = 16'h3F80; beats = 8'd2; relu_en = 1'b0;
      push_word(16'h4000);
      push_word(16'h4040);
      wait_valid(t);
      vectors++;
      if (t + 1 !== 9) begin
         miscompares++;
         $display("FAIL two_beat_latency: got %0d cycles req 9", t + 1);
      end
      vectors++;
      if (ifc.result !== 16'h40C0) begin
         miscompares++;
         $display("FAIL two_beat_result: got %h req 40c0", ifc.result);
      end
      vectors++;
      if (drop_err !== 1'b0) begin
         miscompares++;
         $display("FAIL two_beat_drop: got %b req 0", drop_err);
      end
      accept();
   endtask

   task automatic test_relu();
      int t;
      bias = 16'hC0A0; beats = 8'd1; relu_en = 1'b1;
      push_word(16'h3F80);
      wait_valid(t);
      vectors++;
      if (t !== 5 || ifc.result !== 16'h0000) begin
         miscompares++;
         $display("FAIL relu_on: got %h after %0d req 0000 after 5",
                  ifc.result, t);
      end
      accept();
      relu_en = 1'b0;
      push_word(16'h3F80);
      wait_valid(t);
      vectors++;
      if (t < 0 || ifc.result !== 16'hC080) begin
         miscompares++;
         $display("FAIL relu_off: got %h req c080", ifc.result);
      end
      accept();
   endtask

   task automatic test_cancel();
      int t;
      bias = 16'h4000; beats = 8'd0; relu_en = 1'b0;
      push_word(16'hC000);
      wait_valid(t);
      vectors++;
      if (t < 0 || ifc.result !== 16'h0000) begin
         miscompares++;
         $display("FAIL cancel_beats0: got %h req 0000", ifc.result);
      end
      accept();
   endtask

   task automatic test_back_to_back();
      int t;
      bias = 16'h3F80; beats = 8'd1; relu_en = 1'b0;
      push_word(16'h4000);
      push_word(16'h4040);
      wait_valid(t);
      vectors++;
      if (t < 0 || ifc.result !== 16'h4040) begin
         miscompares++;
         $display("FAIL b2b_first: got %h req 4040", ifc.result);
      end
      bias = 16'hC000;
      accept();
      wait_valid(t);
      vectors++;
      if (t !== 5 || ifc.result !== 16'h3F80) begin
         miscompares++;
         $display("FAIL b2b_second: got %h after %0d req 3f80 after 5",
                  ifc.result, t);
      end
      accept();
   endtask

   task automatic test_random();
      int t, n;
      logic [15:0] acc, w, exp_res;
      logic [7:0]  bt;
      bit          rl;
      for (int k = 0; k < 40; k++) begin
         bt  = 8'($urandom_range(0, 4));
         n   = (bt == 0) ? 1 : int'(bt);
         rl  = 1'($urandom_range(0, 1));
         acc = rnd_bf();
         beats = bt; bias = acc; relu_en = rl;
         for (int j = 0; j < n; j++) begin
            w = rnd_bf();
            acc = m_add(acc, w);
            push_word(w);
            repeat ($urandom_range(0, 2)) @(negedge clock);
         end
         exp_res = (rl && acc[15]) ? 16'h0000 : acc;
         wait_valid(t);
         vectors++;
         if (t < 0 || ifc.result !== exp_res) begin
            miscompares++;
            $display("FAIL random_win%0d: got %h req %h (beats=%0d t=%0d)",
                     k, ifc.result, exp_res, bt, t);
         end
         accept();
      end
      vectors++;
      if (overflow !== m_ovf) begin
         miscompares++;
         $display("FAIL random_overflow: got %b req %b", overflow, m_ovf);
      end
   endtask

   task automatic test_overflow();
      int t;
      bias = 16'h7F7F; beats = 8'd1; relu_en = 1'b0;
      push_word(16'h7F7F);
      wait_valid(t);
      vectors++;
      if (t < 0 || ifc.result !== 16'h7F7F || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow_sat: got %h ovf=%b req 7f7f ovf=1",
                  ifc.result, overflow);
      end
      accept();
      bias = 16'h3F80;
      push_word(16'h3F80);
      wait_valid(t);
      vectors++;
      if (t < 0 || ifc.result !== 16'h4000 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL overflow_sticky: got %h ovf=%b req 4000 ovf=1",
                  ifc.result, overflow);
      end
      accept();
   endtask

   task automatic test_drop();
      bit saw_full;
      vectors++;
      if (drop_err !== 1'b0) begin
         miscompares++;
         $display("FAIL drop_pre: got %b req 0", drop_err);
      end
      bias = 16'h0000; beats = 8'd8; relu_en = 1'b0;
      saw_full = 1'b0;
      for (int i = 0; i < 6; i++) begin
         ifc.data_valid = 1'b1;
         ifc.data       = 16'h3F80;
         if (!ifc.in_ready) saw_full = 1'b1;
         @(negedge clock);
      end
      ifc.data_valid = 1'b0;
      vectors++;
      if (saw_full !== 1'b1 || drop_err !== 1'b1) begin
         miscompares++;
         $display("FAIL drop_full: saw_full=%b drop=%b req 1/1",
                  saw_full, drop_err);
      end
      repeat (5) @(negedge clock);
      vectors++;
      if (drop_err !== 1'b1 || overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL sticky_hold: drop=%b ovf=%b req 1/1",
                  drop_err, overflow);
      end
      do_reset();
      vectors++;
      if (drop_err !== 1'b0 || overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL sticky_clear: drop=%b ovf=%b req 0/0",
                  drop_err, overflow);
      end
   endtask

   task automatic test_stall_reset();
      int t;
      bias = 16'h4000; beats = 8'd1; relu_en = 1'b0;
      push_word(16'h4000);
      wait_valid(t);
      for (int i = 0; i < 10; i++) begin
         vectors++;
         if (ifc.result_valid !== 1'b1 || ifc.result !== 16'h4080) begin
            miscompares++;
            $display("FAIL stall_c%0d: rv=%b res=%h req 1/4080",
                     i, ifc.result_valid, ifc.result);
         end
         @(negedge clock);
      end
      accept();
      beats = 8'd8;
      push_word(16'h3F80);
      push_word(16'h3F80);
      push_word(16'h3F80);
      #2 clock_areset_n = 1'b0;
      #1;
      vectors++;
      if (ifc.result_valid !== 1'b0 || ifc.result !== 16'h0000 ||
          ifc.in_ready !== 1'b1 || overflow !== 1'b0 ||
          drop_err !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset: rv=%b res=%h rdy=%b ovf=%b drop=%b",
                  ifc.result_valid, ifc.result, ifc.in_ready,
                  overflow, drop_err);
      end
      repeat (2) @(negedge clock);
      clock_areset_n = 1'b1;
      beats = 8'd1;
      repeat (20) @(negedge clock);
      vectors++;
      if (ifc.result_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL fifo_flushed: rv=%b req 0", ifc.result_valid);
      end
      bias = 16'h3F80;
      push_word(16'h3F80);
      wait_valid(t);
      vectors++;
      if (t !== 5 || ifc.result !== 16'h4000) begin
         miscompares++;
         $display("FAIL post_reset: got %h after %0d req 4000 after 5",
                  ifc.result, t);
      end
      accept();
   endtask

   initial begin
      vectors          = 0;
      miscompares      = 0;
      m_ovf            = 1'b0;
      clock_areset_n   = 1'b0;
      beats            = 8'd1;
      bias             = 16'h0000;
      relu_en          = 1'b0;
      ifc.data_valid   = 1'b0;
      ifc.data         = 16'h0000;
      ifc.result_ready = 1'b0;
      test_reset();
      test_two_beat();
      test_relu();
      test_cancel();
      test_back_to_back();
      test_random();
      test_overflow();
      test_drop();
      test_stall_reset();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
